// File: rtl/cmd_pin_encoder.sv
// Scheduler command to DDR pin encoder with burst, power-down and reset hold.
// Define CMD_2T_TIMING_EN to hold each pin command for two cycles (2T timing).
package cmd_pin_pkg;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        burst_length;
    logic [13:0] row_addr;
    logic [13:0] col_addr;
    logic [2:0]  bank_addr;
  } bank_command_t;

  localparam logic [3:0] CMD_NOP            = 4'd0;
  localparam logic [3:0] CMD_ACTIVE         = 4'd1;
  localparam logic [3:0] CMD_READ           = 4'd2;
  localparam logic [3:0] CMD_WRITE          = 4'd3;
  localparam logic [3:0] CMD_PRECHARGE      = 4'd4;
  localparam logic [3:0] CMD_REFRESH        = 4'd5;
  localparam logic [3:0] CMD_MRS            = 4'd6;
  localparam logic [3:0] CMD_LOAD_MODE      = 4'd7;
  localparam logic [3:0] CMD_ZQCAL          = 4'd8;
  localparam logic [3:0] CMD_ZQ_CALIBRATION = 4'd9;
  localparam logic [3:0] CMD_POWER_DOWN     = 4'd10;
  localparam logic [3:0] CMD_POWER_UP       = 4'd11;
  localparam logic [3:0] CMD_RESET          = 4'd12;

  localparam logic [3:0] PIN_NOP = 4'b0111;
  localparam logic [3:0] PIN_ACT = 4'b0011;
  localparam logic [3:0] PIN_RD  = 4'b0101;
  localparam logic [3:0] PIN_WR  = 4'b0100;
  localparam logic [3:0] PIN_PRE = 4'b0010;
  localparam logic [3:0] PIN_REF = 4'b0001;
  localparam logic [3:0] PIN_MRS = 4'b0000;
  localparam logic [3:0] PIN_ZQ  = 4'b0110;

endpackage

module cmd_pin_encoder
  import cmd_pin_pkg::*;
#(
  parameter int RESET_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid_i,
  input  bank_command_t cmd_i,
  output logic          cmd_ready_o,
  output logic          ddr_cke,
  output logic          ddr_cs_n,
  output logic          ddr_ras_n,
  output logic          ddr_cas_n,
  output logic          ddr_we_n,
  output logic          ddr_reset_n,
  output logic [2:0]    ddr_ba,
  output logic [13:0]   ddr_addr,
  output logic          rd_window_o,
  output logic          wr_window_o,
  output logic          illegal_o
);

`ifdef CMD_2T_TIMING_EN
  localparam bit TWO_T = 1'b1;
`else
  localparam bit TWO_T = 1'b0;
`endif

  localparam int RW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    PDOWN,
    RST_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [2:0]    bst_cnt_q, bst_cnt_d;
  logic          is_wr_q, is_wr_d;
  logic          hold_q, hold_d;
  logic [3:0]    pins_q, pins_d;
  logic [2:0]    ba_q, ba_d;
  logic [13:0]   addr_q, addr_d;
  logic          cke_q, cke_d;
  logic          rstn_q, rstn_d;
  logic          rdw_q, rdw_d;
  logic          wrw_q, wrw_d;
  logic          ill_q, ill_d;
  logic          rdy_q, rdy_d;

  logic [3:0]    enc_pins;
  logic [2:0]    enc_ba;
  logic [13:0]   enc_addr;
  logic [13:0]   rw_addr;
  logic          enc_pin;
  logic          xfer;

  assign xfer = cmd_valid_i & rdy_q;

  // A10 forced low (no auto-precharge), A12 selects BL8
  always_comb begin
    rw_addr     = cmd_i.col_addr;
    rw_addr[10] = 1'b0;
    rw_addr[12] = cmd_i.burst_length;
  end

  always_comb begin
    enc_pins = PIN_NOP;
    enc_ba   = 3'd0;
    enc_addr = 14'd0;
    enc_pin  = 1'b0;
    unique case (cmd_i.cmd)
      CMD_ACTIVE: begin
        enc_pins = PIN_ACT;
        enc_ba   = cmd_i.bank_addr;
        enc_addr = cmd_i.row_addr;
        enc_pin  = 1'b1;
      end
      CMD_READ, CMD_WRITE: begin
        enc_pins = (cmd_i.cmd == CMD_WRITE) ? PIN_WR : PIN_RD;
        enc_ba   = cmd_i.bank_addr;
        enc_addr = rw_addr;
        enc_pin  = 1'b1;
      end
      CMD_PRECHARGE: begin
        enc_pins = PIN_PRE;
        enc_ba   = cmd_i.bank_addr;
        enc_pin  = 1'b1;
      end
      CMD_REFRESH: begin
        enc_pins = PIN_REF;
        enc_pin  = 1'b1;
      end
      CMD_MRS, CMD_LOAD_MODE: begin
        enc_pins = PIN_MRS;
        enc_ba   = cmd_i.bank_addr;
        enc_addr = cmd_i.row_addr;
        enc_pin  = 1'b1;
      end
      CMD_ZQCAL, CMD_ZQ_CALIBRATION: begin
        enc_pins = PIN_ZQ;
        enc_addr = 14'h0400;
        enc_pin  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    bst_cnt_d = bst_cnt_q;
    is_wr_d   = is_wr_q;
    hold_d    = 1'b0;
    pins_d    = PIN_NOP;
    ba_d      = 3'd0;
    addr_d    = 14'd0;
    cke_d     = cke_q;
    rstn_d    = 1'b1;
    rdw_d     = 1'b0;
    wrw_d     = 1'b0;
    ill_d     = 1'b0;
    rdy_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (hold_q) begin
          pins_d = pins_q;
          ba_d   = ba_q;
          addr_d = addr_q;
        end else if (xfer) begin
          pins_d = enc_pins;
          ba_d   = enc_ba;
          addr_d = enc_addr;
          hold_d = TWO_T && enc_pin;
          if (TWO_T && enc_pin) rdy_d = 1'b0;
          unique case (cmd_i.cmd)
            CMD_READ, CMD_WRITE: begin
              state_d   = BURST;
              bst_cnt_d = cmd_i.burst_length ? 3'd4 : 3'd2;
              is_wr_d   = (cmd_i.cmd == CMD_WRITE);
              rdy_d     = 1'b0;
            end
            CMD_POWER_DOWN: begin
              cke_d   = 1'b0;
              state_d = PDOWN;
            end
            CMD_POWER_UP: cke_d = 1'b1;
            CMD_RESET: begin
              state_d   = RST_HOLD;
              rst_cnt_d = RW'(RESET_CYCLES - 1);
              cke_d     = 1'b0;
              rdy_d     = 1'b0;
              hold_d    = TWO_T;
              rstn_d    = TWO_T;
            end
            CMD_NOP, CMD_ACTIVE, CMD_PRECHARGE,
            CMD_REFRESH, CMD_MRS, CMD_LOAD_MODE,
            CMD_ZQCAL, CMD_ZQ_CALIBRATION: ;
            default: ill_d = 1'b1;
          endcase
        end
      end
      BURST: begin
        if (hold_q) begin
          pins_d = pins_q;
          ba_d   = ba_q;
          addr_d = addr_q;
        end else if (bst_cnt_q != 3'd0) begin
          rdw_d     = ~is_wr_q;
          wrw_d     = is_wr_q;
          bst_cnt_d = bst_cnt_q - 3'd1;
        end else begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end
      end
      PDOWN: begin
        rdy_d = 1'b1;
        if (xfer) begin
          if (cmd_i.cmd == CMD_POWER_UP) begin
            cke_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      RST_HOLD: begin
        cke_d = 1'b0;
        if (hold_q) begin
          rstn_d = 1'b0;
        end else if (rst_cnt_q == '0) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end else begin
          rstn_d    = 1'b0;
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      bst_cnt_q <= 3'd0;
      is_wr_q   <= 1'b0;
      hold_q    <= 1'b0;
      pins_q    <= PIN_NOP;
      ba_q      <= 3'd0;
      addr_q    <= 14'd0;
      cke_q     <= 1'b0;
      rstn_q    <= 1'b0;
      rdw_q     <= 1'b0;
      wrw_q     <= 1'b0;
      ill_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      bst_cnt_q <= bst_cnt_d;
      is_wr_q   <= is_wr_d;
      hold_q    <= hold_d;
      pins_q    <= pins_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
      cke_q     <= cke_d;
      rstn_q    <= rstn_d;
      rdw_q     <= rdw_d;
      wrw_q     <= wrw_d;
      ill_q     <= ill_d;
      rdy_q     <= rdy_d;
    end
  end

  assign {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = pins_q;
  assign ddr_ba      = ba_q;
  assign ddr_addr    = addr_q;
  assign ddr_cke     = cke_q;
  assign ddr_reset_n = rstn_q;
  assign rd_window_o = rdw_q;
  assign wr_window_o = wrw_q;
  assign illegal_o   = ill_q;
  assign cmd_ready_o = rdy_q;

endmodule

// File: doc/cmd_pin_encoder.md
CMD_PIN_ENCODER -- requirements
Module: cmd_pin_encoder

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: number of cycles ddr_reset_n is held low after CMD_RESET.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid_i, input, 1: scheduler command valid.
REQ-005 SHALL have port cmd_i, input, 36, packed bank_command_t: cmd[35:32], burst_length[31], row_addr[30:17], col_addr[16:3], bank_addr[2:0].
REQ-006 SHALL have port cmd_ready_o, output, 1: encoder can accept; transfer occurs when cmd_valid_i and cmd_ready_o are both high.
REQ-007 SHALL have ports ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n, ddr_reset_n, each output, 1: DRAM control pins.
REQ-008 SHALL have ports ddr_ba, output, 3, and ddr_addr, output, 14: DRAM bank and address pins.
REQ-009 SHALL have ports rd_window_o and wr_window_o, each output, 1: read/write data burst window flags.
REQ-010 SHALL have port illegal_o, output, 1: one-cycle pulse when an accepted command is dropped.

Function
REQ-011 SHALL register all pin outputs; a command accepted in cycle N appears on the pins in cycle N+1.
REQ-012 SHALL encode {cs_n,ras_n,cas_n,we_n} as: NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, REFRESH 0001, MRS/LOAD_MODE 0000, ZQCAL/ZQ_CALIBRATION 0110.
REQ-013 SHALL drive ddr_ba = bank_addr for ACTIVE, READ, WRITE, PRECHARGE, MRS and LOAD_MODE; otherwise 0.
REQ-014 SHALL drive ddr_addr as follows: ACTIVE = row_addr; MRS/LOAD_MODE = row_addr; READ/WRITE = col_addr with A10 = 0 and A12 = burst_length (1 = BL8); PRECHARGE = 0 (single bank); ZQ = A10 = 1, all other bits 0; otherwise 0.
REQ-015 SHALL implement states IDLE, BURST, PDOWN and RST_HOLD.
REQ-016 In IDLE, SHALL hold cmd_ready_o = 1 and drive NOP on the pins in any cycle with no transfer.
REQ-017 On READ/WRITE issue, SHALL enter BURST and assert rd_window_o/wr_window_o from cycle N+2 for 2 cycles (BL4) or 4 cycles (BL8); cmd_ready_o SHALL be 0 from cycle N+1 until the window's last cycle, then 1.
REQ-018 On POWER_DOWN accept, SHALL drive ddr_cke = 0 and a NOP from cycle N+1 and enter PDOWN.
REQ-019 In PDOWN, cmd_ready_o SHALL stay 1; POWER_UP SHALL set ddr_cke = 1 at N+1 and return to IDLE; any other accepted command SHALL be dropped, pulse illegal_o at N+1, and leave the pins unchanged.
REQ-020 POWER_UP accepted in IDLE SHALL issue a NOP with no state change.
REQ-021 On RESET accept, SHALL drive ddr_reset_n = 0 and ddr_cke = 0 for exactly RESET_CYCLES cycles starting at N+1, with cmd_ready_o = 0; it SHALL then release ddr_reset_n = 1, hold cke 0, and return to IDLE. cke SHALL be raised only by a POWER_UP.
REQ-022 Command codes 13-15 SHALL be accepted, issue a NOP, and pulse illegal_o.
REQ-023 The RST_HOLD and burst counters SHALL be sized to hold RESET_CYCLES and 4 respectively, with no wrap.

Reset
REQ-024 While rst is high, SHALL set: state IDLE, ddr_cke = 0, ddr_reset_n = 0, NOP pins, ddr_ba = 0, ddr_addr = 0, windows 0, illegal_o = 0, cmd_ready_o = 0.
REQ-025 After rst falls, ddr_reset_n SHALL be 1 and cmd_ready_o 1 in the first cycle; ddr_cke SHALL stay 0 until POWER_UP.
REQ-026 rst asserted mid-BURST or mid-RST_HOLD SHALL abort the operation immediately at the next edge.

Configuration
REQ-027 With macro CMD_2T_TIMING_EN defined, every non-NOP command SHALL hold its pins for 2 cycles (N+1, N+2) with cmd_ready_o = 0 at N+1, and all later timings (windows, RST_HOLD) SHALL shift by one cycle.
REQ-028 Without CMD_2T_TIMING_EN, commands SHALL occupy 1 cycle, as described above.

Verification
REQ-029 Reset release, then POWER_UP -> cke = 1 at N+1; ACTIVE bank 3 row 0x1ABC -> pins 0011, ba = 3, addr = 0x1ABC at N+1.
REQ-030 READ BL8, col 0x0040 -> pins 0101, addr = 0x1040, rd_window_o high for cycles N+2..N+5, cmd_ready_o low for N+1..N+5.
REQ-031 WRITE BL4 -> wr_window_o high for N+2..N+3, addr A12 = 0, ready returns to 1 at N+4.
REQ-032 POWER_DOWN, then READ -> READ dropped, illegal_o pulse, cke stays 0; then POWER_UP -> cke = 1.
REQ-033 RESET with RESET_CYCLES = 16 -> ddr_reset_n low for exactly 16 cycles, ready low throughout; rst asserted mid-hold -> IDLE next cycle.
REQ-034 Compiled with CMD_2T_TIMING_EN: ACTIVE -> pins 0011 for 2 consecutive cycles, then NOP.
